// File: rtl/set_pkg.sv
// Shared opcode encodings and set-word constants for the SEQ/SNE/SLT/SGT/SLE/SGE family.
package set_pkg;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] SET_EQ = 3'd0;
  localparam logic [OPW-1:0] SET_NE = 3'd1;
  localparam logic [OPW-1:0] SET_LT = 3'd2;
  localparam logic [OPW-1:0] SET_GT = 3'd3;
  localparam logic [OPW-1:0] SET_LE = 3'd4;
  localparam logic [OPW-1:0] SET_GE = 3'd5;

  localparam logic [31:0] SET_TRUE  = 32'h0000_0001;
  localparam logic [31:0] SET_FALSE = 32'h0000_0000;
endpackage

// File: rtl/set_resolve.sv
// Combinational condition resolution from unsigned subtract flags (ne, cout) to a 32-bit set word.
// Zero latency; no handshake. Reserved opcodes yield SET_FALSE and raise err.
module set_resolve #(
  parameter int OPW = set_pkg::OPW
) (
  input  logic           ne,
  input  logic           cout,
  input  logic [OPW-1:0] op,
  output logic [31:0]    set,
  output logic           err
);
  import set_pkg::*;

  logic cond;

  always_comb begin
    cond = 1'b0;
    err  = 1'b0;
    // cout is the no-borrow flag of a - b, i.e. a >= b unsigned
    case (op)
      SET_EQ:  cond = !ne;
      SET_NE:  cond = ne;
      SET_LT:  cond = !cout;
      SET_GT:  cond = cout & ne;
      SET_LE:  cond = !cout | !ne;
      SET_GE:  cond = cout;
      default: err  = 1'b1;
    endcase
    set = cond ? SET_TRUE : SET_FALSE;
  end
endmodule

// File: rtl/set_flag_stage.sv
// Two-stage valid/ready compare pipeline: stage 1 registers subtract flags, stage 2 the resolved set word.
// Latency 2, throughput 1/cycle; in_ready depends only on pipeline occupancy and out_ready.
module set_flag_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = set_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic             cout,
  output logic [31:0]      set,
  output logic [OPW-1:0]   out_op,
  output logic             out_err
);
  logic [WIDTH:0]   diff;
  logic             diff_ne;
  logic             s1_valid;
  logic             s1_ne;
  logic             s1_cout;
  logic [OPW-1:0]   s1_op;
  logic             s2_adv;
  logic             s1_adv;
  logic [31:0]      res_set;
  logic             res_err;

  // a + ~b + 1 at WIDTH+1 bits so the top bit is the carry-out
  assign diff    = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_ne = |diff[WIDTH-1:0];

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  set_resolve #(.OPW(OPW)) u_resolve (
    .ne   (s1_ne),
    .cout (s1_cout),
    .op   (s1_op),
    .set  (res_set),
    .err  (res_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_ne     <= 1'b0;
      s1_cout   <= 1'b0;
      s1_op     <= '0;
      out_valid <= 1'b0;
      out       <= 1'b0;
      cout      <= 1'b0;
      set       <= 32'h0;
      out_op    <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ne   <= diff_ne;
          s1_cout <= diff[WIDTH];
          s1_op   <= in_op;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out     <= s1_ne;
          cout    <= s1_cout;
          set     <= res_set;
          out_op  <= s1_op;
          out_err <= res_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_set_flag_stage.sv
// Directed bench for set_flag_stage: table-driven streaming vectors plus stall and reset sequences.
module tb_set_flag_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic        out;
  logic        cout;
  logic [31:0] set;
  logic [2:0]  out_op;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  set_flag_stage #(.WIDTH(32), .OPW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .set       (set),
    .out_op    (out_op),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        e_out;
    logic        e_cout;
    logic [31:0] e_set;
    logic        e_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  // result bundle: {out_valid, out, cout, set, out_op, out_err}
  function automatic logic [38:0] pack_dut();
    return {out_valid, out, cout, set, out_op, out_err};
  endfunction

  function automatic logic [38:0] pack_exp(input vec_t v);
    return {1'b1, v.e_out, v.e_cout, v.e_set, v.op, v.e_err};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {38'h0, act}, {38'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input vec_t x);
    in_valid = v;
    in_a     = x.a;
    in_b     = x.b;
    in_op    = x.op;
  endtask

  initial begin
    //         a             b             op    out   cout  set            err
    vec[0]  = '{32'd5,        32'd5,        3'd0, 1'b0, 1'b1, 32'h1, 1'b0};
    vec[1]  = '{32'd5,        32'd5,        3'd1, 1'b0, 1'b1, 32'h0, 1'b0};
    vec[2]  = '{32'h0,        32'hFFFFFFFF, 3'd2, 1'b1, 1'b0, 32'h1, 1'b0};
    vec[3]  = '{32'hFFFFFFFF, 32'h0,        3'd3, 1'b1, 1'b1, 32'h1, 1'b0};
    vec[4]  = '{32'd7,        32'd7,        3'd4, 1'b0, 1'b1, 32'h1, 1'b0};
    vec[5]  = '{32'd3,        32'd9,        3'd5, 1'b1, 1'b0, 32'h0, 1'b0};
    vec[6]  = '{32'd1,        32'd2,        3'd6, 1'b1, 1'b0, 32'h0, 1'b1};
    vec[7]  = '{32'd9,        32'd3,        3'd2, 1'b1, 1'b1, 32'h0, 1'b0};
    vec[8]  = '{32'd3,        32'd3,        3'd3, 1'b0, 1'b1, 32'h0, 1'b0};
    vec[9]  = '{32'd9,        32'd3,        3'd4, 1'b1, 1'b1, 32'h0, 1'b0};
    vec[10] = '{32'd9,        32'd9,        3'd5, 1'b0, 1'b1, 32'h1, 1'b0};
    vec[11] = '{32'd1,        32'd2,        3'd0, 1'b1, 1'b0, 32'h0, 1'b0};
    vec[12] = '{32'h0,        32'h0,        3'd7, 1'b0, 1'b1, 32'h0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    tick();
    tick();
    check("reset_state", pack_dut(), 39'h0);
    check1("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();
    check1("idle_out_valid", out_valid, 1'b0);

    // Streaming: after edge k the output holds vec[k-1], no bubbles.
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        drive(1'b1, vec[k]);
        check1($sformatf("stream_in_ready_%0d", k), in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 1)
        check($sformatf("stream_res_%0d", k - 1), pack_dut(), pack_exp(vec[k - 1]));
    end
    tick();
    check1("stream_drained", out_valid, 1'b0);

    // Backpressure: two accepts fill the pipe, then out_ready held low.
    drive(1'b1, vec[3]);
    tick();
    drive(1'b1, vec[5]);
    tick();
    check("bp_first", pack_dut(), pack_exp(vec[3]));
    out_ready = 1'b0;
    drive(1'b1, vec[10]);
    #1;
    check1("bp_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_%0d", i), pack_dut(), pack_exp(vec[3]));
      check1($sformatf("bp_ready_%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check1("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_drain_1", pack_dut(), pack_exp(vec[5]));
    tick();
    check("bp_drain_2", pack_dut(), pack_exp(vec[10]));
    tick();
    check1("bp_no_dup", out_valid, 1'b0);

    // Reset during a stall with two operations in flight.
    out_ready = 1'b0;
    drive(1'b1, vec[0]);
    tick();
    drive(1'b1, vec[6]);
    tick();
    in_valid = 1'b0;
    check("rs_stalled", pack_dut(), pack_exp(vec[0]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_cleared", pack_dut(), 39'h0);
    check1("rs_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1($sformatf("rs_no_stale_%0d", i), out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/set_flag_stage.md
Name: set_flag_stage

Overview:
- Execute-stage compare unit directly upstream of the SEQ/SNE/SLT/SGT/SLE/SGE set logic.
- Computes a - b as a + ~b + 1 and derives two flags:
  - out = difference non-zero.
  - cout = adder carry-out.
- Two-stage valid/ready pipeline. Stage 1 registers the flags. Stage 2 registers the resolved 32-bit set word alongside the flags, so the downstream set logic and writeback consume a single registered result.
- All comparisons are unsigned.

Parameters:
- WIDTH, 32, operand width in bits; the set word is always 32 bits.
- OPW, 3, width of the condition opcode.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- in_op  input  OPW  condition: 0 SEQ, 1 SNE, 2 SLT, 3 SGT, 4 SLE, 5 SGE, 6-7 reserved.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out  output  1  1 when a != b.
- cout  output  1  carry-out of a + ~b + 1 (1 when a >= b unsigned).
- set  output  32  0x00000001 if the condition holds, else 0x00000000.
- out_op  output  OPW  opcode carried with the result.
- out_err  output  1  reserved opcode flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - s1_valid, out_valid, out, cout, out_err = 0; set = 0; out_op = 0.
  - Any in-flight operations are discarded.
  - in_ready is 1 in the first cycle after reset.
- Transfers: in on in_valid & in_ready; out on out_valid & out_ready.
- Stage 1:
  - Registers s1_ne = |(a - b), s1_cout, s1_op.
  - Subtract is WIDTH+1 bits; cout is bit WIDTH.
  - a == b gives ne=0, cout=1.
- Stage 2 resolves set from the registered flags:
  - SEQ: !ne
  - SNE: ne
  - SLT: !cout
  - SGT: cout & ne
  - SLE: !cout | !ne
  - SGE: cout
  - Reserved op: set = 0, out_err = 1.
- Handshake and pipelining:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no combinational in_valid -> in_ready path).
- Latency: accepted in cycle N, out_valid in cycle N+2 when unstalled. Throughput is 1 op per cycle.
- Stall: while out_valid & !out_ready, out, cout, set, out_op and out_err hold stable. Stage 1 holds if occupied; in_ready falls only when both stages are full.
- Simultaneous events: an output drain and an input accept in the same cycle both complete; no bubble is inserted.
- Data not presented: payload registers do not update when their stage does not advance.
- Reset mid-stall: the pipeline empties; no stale result appears after reset.
- Boundaries:
  - a=0, b=0xFFFFFFFF: cout=0, ne=1.
  - a=0xFFFFFFFF, b=0: cout=1, ne=1.
  - Operands never produce X on the flags.

Decomposition:
- Shared package (set_pkg) holds:
  - the opcode localparams SET_EQ=0 … SET_GE=5;
  - the SET_TRUE=32'h1 and SET_FALSE=32'h0 constants;
  - OPW.
- Stage 2 condition resolution is one natural sub-module, set_resolve: inputs ne, cout, op; outputs set, err. It is pure combinational and reusable by the existing set modules.
- The subtractor stays inline in set_flag_stage.

Test Plan:
- Reset then idle: rst high for 2 cycles -> out_valid=0, set=0, in_ready=1.
- SEQ with a=5, b=5, out_ready=1 -> at N+2: out=0, cout=1, set=0x1. Repeat as SNE -> set=0x0.
- Unsigned extremes:
  - SLT a=0, b=0xFFFFFFFF -> cout=0, set=0x1.
  - SGT a=0xFFFFFFFF, b=0 -> set=0x1.
  - SLE a=7, b=7 -> set=0x1.
  - SGE a=3, b=9 -> set=0x0.
- Back-to-back ops 0..5 on consecutive cycles with out_ready=1 -> six results on consecutive cycles, in order, no bubbles.
- Backpressure: hold out_ready=0 after the first result -> in_ready falls after two accepts and the outputs stay stable; release -> results drain in order, nothing lost or duplicated.
- in_op=6 -> set=0, out_err=1. Separately, assert rst during a stall with 2 ops in flight -> out_valid=0 the next cycle and neither op emerges.
